// File: rtl/out_channel.sv
// Output channel: circular buffer fed by the executor "out" strobe and drained by a
// valid/ready consumer. It tracks occupancy, a running word total and a sticky drop flag.
module out_channel #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          outWrite,
  input  logic [MemoryElementWidth-1:0] outData,
  output logic                          outReady,
  output logic                          readValid,
  output logic [MemoryElementWidth-1:0] readData,
  input  logic                          readReady,
  output logic [$clog2(NOut+1)-1:0]     count,
  output logic [31:0]                   written,
  output logic                          overflow
);

  localparam int CW = $clog2(NOut + 1);
  localparam int PW = $clog2(NOut);

  typedef enum logic [1:0] {
    EMPTY,
    ACTIVE,
    FULL
  } state_t;

  logic [MemoryElementWidth-1:0] mem [NOut];
  logic [PW-1:0]                 out_mem_pos;
  logic [PW-1:0]                 read_pos;
  state_t                        state;
  logic                          do_read;
  logic                          do_write;

  // Pointers wrap explicitly because NOut need not be a power of two.
  function automatic logic [PW-1:0] next_pos(input logic [PW-1:0] p);
    return (p == PW'(NOut - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: always_comb assigns a default first so no path can leave state unassigned (no latch).
  always_comb begin
    state = ACTIVE;
    if (count == '0)
      state = EMPTY;
    else if (count == CW'(NOut))
      state = FULL;
  end

  assign readValid = (state != EMPTY);
  assign do_read   = readValid && readReady;
  // A full buffer still accepts a write when the same edge frees the oldest slot.
  assign outReady  = (state != FULL) || do_read;
  assign do_write  = outWrite && outReady;
  assign readData  = readValid ? mem[read_pos] : '0;

  // NOTE: the storage array has no reset; count and readValid hide stale contents,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (do_write && !clear)
      mem[out_mem_pos] <= outData;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_mem_pos <= '0;
      read_pos    <= '0;
      count       <= '0;
      written     <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      out_mem_pos <= '0;
      read_pos    <= '0;
      count       <= '0;
      written     <= '0;
      overflow    <= 1'b0;
    end else begin
      if (do_write) begin
        out_mem_pos <= next_pos(out_mem_pos);
        written     <= written + 32'd1;
      end
      if (do_read)
        read_pos <= next_pos(read_pos);
      if (outWrite && !outReady)
        overflow <= 1'b1;
      case ({do_write, do_read})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/out_channel.md
OUT_CHANNEL -- requirements
Module: out_channel

Interface
REQ-001 The module SHALL have parameter MemoryElementWidth, default 12, meaning width of each output word.
REQ-002 The module SHALL have parameter NOut, default 8, legal range 2..4096 (any value, not only powers of two), meaning output channel depth in words.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 clear  input  1  synchronous flush of the channel.
REQ-007 outWrite  input  1  executor "out" instruction strobe, one word per cycle.
REQ-008 outData  input  MemoryElementWidth  word to append.
REQ-009 outReady  output  1  high when a write this cycle will be accepted.
REQ-010 readValid  output  1  high when readData holds the oldest unread word.
REQ-011 readData  output  MemoryElementWidth  oldest unread word; 0 when readValid is low.
REQ-012 readReady  input  1  consumer accepts readData this cycle.
REQ-013 count  output  $clog2(NOut+1)  words currently held.
REQ-014 written  output  32  total words accepted since reset/clear, wraps modulo 2^32.
REQ-015 overflow  output  1  sticky flag: a write was dropped.

Function
REQ-016 Storage SHALL be a circular buffer of NOut words with write pointer outMemPos and read pointer readPos; both SHALL advance as (pos+1) modulo NOut, so the pointer at NOut-1 wraps to 0.
REQ-017 State SHALL be one of EMPTY (count=0), ACTIVE (0<count<NOut), or FULL (count=NOut), derived from count.
REQ-018 readValid SHALL equal (count!=0); outReady SHALL equal (count!=NOut) or (readValid and readReady).
REQ-019 A read SHALL occur on a rising edge when readValid and readReady are both high; readPos advances and count decrements.
REQ-020 A write SHALL occur on a rising edge when outWrite and outReady are both high; outData is stored at outMemPos, outMemPos advances, count increments, and written increments.
REQ-021 Simultaneous read and write SHALL both take effect with count unchanged, including in FULL, where the slot being read is freed and refilled that cycle.
REQ-022 outWrite with outReady low (FULL and no read) SHALL drop the word, leave pointers, count, and written unchanged, and set overflow.
REQ-023 readReady while EMPTY SHALL have no effect.
REQ-024 A word written on edge N SHALL be presented on readData with readValid high after edge N; write-to-read latency is one cycle.
REQ-025 readData SHALL be combinational from buffer[readPos], gated to 0 when count=0.
REQ-026 clear SHALL take priority over read and write in the same cycle: pointers, count, written, and overflow go to 0, and the concurrent write is discarded without setting overflow.
REQ-027 Buffer contents SHALL NOT be required to be zeroed by reset or clear; the effect is visible only through count and readValid.

Reset
REQ-028 While reset=0, regardless of clock: outMemPos=0, readPos=0, count=0, written=0, overflow=0, readValid=0, readData=0, outReady=1.
REQ-029 Assertion of reset mid-operation SHALL discard all held words immediately; the first edge after deassertion SHALL behave as in EMPTY.

Verification
REQ-030 NOut=3: write 1,2,3 on consecutive cycles -> count=3, outReady=0; write 4 -> dropped, overflow=1, written=3; read three times -> 1,2,3, then readValid=0, readData=0.
REQ-031 NOut=3: write 1..5, reading each word one cycle after it is written -> reads return 1..5 in order, pointers wrap past 2 to 0, overflow=0, written=5.
REQ-032 FULL (NOut=3, holding 7,8,9) with outWrite=10 and readReady both high in one cycle -> read returns 7, count stays 3, subsequent reads return 8,9,10, overflow=0.
REQ-033 Holding 2 words with overflow=1: assert clear together with outWrite and readReady -> next cycle count=0, written=0, overflow=0, readValid=0.
REQ-034 Drop reset to 0 asynchronously between edges while holding 2 words -> outputs reach reset values without a clock edge; after release, write 5 then read -> returns 5.
REQ-035 Single write of 0xABC (width 12) -> readValid=0 in the write cycle, then readValid=1 and readData=0xABC one cycle later.
